// File: rtl/memc3_burst_writer.sv
// memc3_burst_writer: streams 32-bit words into MCB port 0 and issues write bursts over a wrapping address window.
// Optional cmd_full stall timeout is enabled by defining MEMC3_WR_TIMEOUT_EN.
module memc3_burst_writer #(
    parameter int          BURST_LEN      = 32,
    parameter logic [29:0] BASE_ADDR      = 30'h0000_0000,
    parameter logic [29:0] ADDR_LIMIT     = 30'h0400_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk0,
    input  logic        sys_rst_n,
    input  logic        pll_lock,
    input  logic        calib_done,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    input  logic        cmd_full,
    output logic        wr_en,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_mask,
    input  logic        wr_full,
    input  logic        wr_underrun,
    input  logic        wr_error,
    output logic        busy,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [31:0] words_written
);
    typedef enum logic [2:0] {WAIT_CAL, IDLE, FILL, CMD, ERROR} state_t;

    state_t      state;
    logic [29:0] addr;
    logic [6:0]  beat_cnt;
    logic [29:0] rem;
    logic [6:0]  cap;
    logic [29:0] next_addr;
    logic        take;
    logic        fault_mcb;
    logic        fault_cal;
    logic        fault_to;
    logic        live;

    // Cap the burst at the words left before the wrap point.
    assign rem       = (ADDR_LIMIT - addr) >> 2;
    assign cap       = (rem < 30'(BURST_LEN)) ? rem[6:0] : 7'(BURST_LEN);
    assign next_addr = addr + {21'b0, beat_cnt, 2'b00};
    assign in_ready  = (state == IDLE || state == FILL) & ~wr_full & (beat_cnt < cap) & ~flush;
    assign take      = in_valid & in_ready;
    assign wr_en     = take;
    assign wr_data   = take ? in_data : 32'h0;
    assign wr_mask   = 4'b0000;
    assign cmd_en    = (state == CMD);
    assign cmd_instr = 3'b000;
    assign cmd_bl    = cmd_en ? 6'(beat_cnt - 7'd1) : 6'h0;
    assign cmd_byte_addr = cmd_en ? addr : 30'h0;
    assign busy      = (state != IDLE);
    assign error     = (state == ERROR);
    assign live      = (state != WAIT_CAL) && (state != ERROR);
    assign fault_mcb = wr_underrun | wr_error;
    assign fault_cal = ~calib_done | ~pll_lock;

`ifdef MEMC3_WR_TIMEOUT_EN
    logic [15:0] to_cnt;

    assign fault_to = (state == CMD) & cmd_full & (to_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk0 or negedge sys_rst_n) begin
        if (!sys_rst_n)
            to_cnt <= 16'h0;
        else
            to_cnt <= (state != CMD) ? 16'h0 : (cmd_full ? to_cnt + 16'h1 : to_cnt);
    end
`else
    assign fault_to = 1'b0;
`endif

    always_ff @(posedge clk0 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= WAIT_CAL;
            addr          <= BASE_ADDR;
            beat_cnt      <= 7'h0;
            err_code      <= 2'b00;
            words_written <= 32'h0;
        end else if (live && (fault_mcb || fault_cal || fault_to)) begin
            // Faults win over a same-cycle handshake, so an in-flight burst is never counted.
            state    <= ERROR;
            err_code <= fault_mcb ? 2'b01 : (fault_cal ? 2'b10 : 2'b11);
        end else begin
            case (state)
                WAIT_CAL: if (pll_lock && calib_done) state <= IDLE;
                IDLE, FILL: begin
                    if (take)
                        beat_cnt <= beat_cnt + 7'd1;
                    if (take && (beat_cnt + 7'd1 == cap))
                        state <= CMD;
                    else if (take)
                        state <= FILL;
                    else if (state == FILL && flush && beat_cnt != 7'h0)
                        state <= CMD;
                end
                CMD: if (!cmd_full) begin
                    addr          <= (next_addr == ADDR_LIMIT) ? BASE_ADDR : next_addr;
                    words_written <= words_written + 32'(beat_cnt);
                    beat_cnt      <= 7'h0;
                    state         <= IDLE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_memc3_burst_writer.sv
// tb_memc3_burst_writer: directed scoreboard bench for memc3_burst_writer (small ADDR_LIMIT to exercise wrap).
module tb_memc3_burst_writer;
    localparam int          BL   = 32;
    localparam logic [29:0] BASE = 30'h0;
    localparam logic [29:0] LIM  = 30'h100;

    logic        clk0 = 1'b0;
    logic        sys_rst_n, pll_lock, calib_done;
    logic [31:0] in_data;
    logic        in_valid, in_ready, flush;
    logic        cmd_en, cmd_full, wr_en, wr_full, wr_underrun, wr_error;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic [31:0] wr_data, words_written;
    logic [3:0]  wr_mask;
    logic        busy, error;
    logic [1:0]  err_code;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] dq[$];
    logic [35:0] cq[$];
    int          m_cnt;
    logic [29:0] m_addr;
    logic [31:0] ww_hold;

    memc3_burst_writer #(.BURST_LEN(BL), .BASE_ADDR(BASE), .ADDR_LIMIT(LIM), .TIMEOUT_CYCLES(1024)) dut (
        .clk0(clk0), .sys_rst_n(sys_rst_n), .pll_lock(pll_lock), .calib_done(calib_done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
        .cmd_full(cmd_full), .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
        .wr_underrun(wr_underrun), .wr_error(wr_error), .busy(busy), .error(error),
        .err_code(err_code), .words_written(words_written)
    );

    always #5 clk0 = ~clk0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        assert (act === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    endtask

    function automatic int m_cap();
        int r = int'((LIM - m_addr) >> 2);
        return (r < BL) ? r : BL;
    endfunction

    task automatic commit();
        cq.push_back({6'(m_cnt - 1), m_addr});
        m_addr = m_addr + 30'(4 * m_cnt);
        if (m_addr == LIM) m_addr = BASE;
        m_cnt = 0;
    endtask

    task automatic send(input logic [31:0] d);
        bit ok = 1'b0;
        dq.push_back(d);
        in_data  = d;
        in_valid = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk0);
            ok = in_ready;
            @(posedge clk0);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'(ok), 64'd1);
        m_cnt++;
        if (m_cnt == m_cap()) commit();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk0);
        #1;
        flush = 1'b0;
        if (m_cnt > 0) commit();
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        {in_valid, flush, cmd_full, wr_full, wr_underrun, wr_error} = '0;
        calib_done = 1'b1;
        pll_lock   = 1'b1;
        repeat (2) @(posedge clk0);
        dq.delete();
        cq.delete();
        m_cnt  = 0;
        m_addr = BASE;
        #1 sys_rst_n = 1'b1;
        for (int n = 0; n < 10 && busy; n++) @(negedge clk0);
        chk("reset_idle", 64'(busy), 64'd0);
    endtask

    // Scoreboard: every write beat and every command handshake must match a queued expectation.
    always @(negedge clk0) begin
        logic [63:0] e;
        if (sys_rst_n) begin
            if (wr_en) begin
                e = dq.size() > 0 ? 64'(dq.pop_front()) : {64{1'bx}};
                chk("wr_data", 64'(wr_data), e);
            end
            if (cmd_en && !cmd_full) begin
                e = cq.size() > 0 ? 64'({cq.pop_front(), 7'b0}) : {64{1'bx}};
                chk("cmd", 64'({cmd_bl, cmd_byte_addr, cmd_instr, wr_mask}), e);
            end
        end
    end

    initial begin
        sys_rst_n = 1'b1;
        {in_valid, flush, cmd_full, wr_full, wr_underrun, wr_error} = '0;
        in_data = 32'h0; pll_lock = 1'b1; calib_done = 1'b0;
        m_cnt = 0; m_addr = BASE;
        #1 sys_rst_n = 1'b0;
        @(negedge clk0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_cmd_en", 64'(cmd_en), 64'd0);
        chk("rst_error", 64'({error, err_code}), 64'd0);
        chk("rst_words", 64'(words_written), 64'd0);
        @(posedge clk0);
        #1 sys_rst_n = 1'b1;
        // Calibration arrives 50 cycles after reset release.
        repeat (49) @(posedge clk0);
        #1 calib_done = 1'b1;
        in_valid = 1'b1;
        @(negedge clk0);
        chk("cal_in_ready", 64'(in_ready), 64'd0);
        chk("cal_busy", 64'(busy), 64'd1);
        @(posedge clk0);
        #1 in_valid = 1'b0;
        @(negedge clk0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk0);
        #1;
        // Two full bursts back-to-back; command must follow the 32nd beat by one cycle.
        for (int i = 0; i < 64; i++) begin
            send(32'hA000_0000 + 32'(i));
            if (i % 32 == 31) begin
                @(negedge clk0);
                chk("burst_latency", 64'(cmd_en), 64'd1);
            end
        end
        repeat (2) @(negedge clk0);
        chk("words_64", 64'(words_written), 64'd64);
        // Flush in IDLE does nothing.
        @(posedge clk0);
        #1 do_flush();
        repeat (3) begin
            @(negedge clk0);
            chk("idle_flush", 64'(cmd_en), 64'd0);
        end
        @(posedge clk0);
        #1;
        for (int i = 0; i < 5; i++) send(32'hB000_0000 + 32'(i));
        do_flush();
        for (int i = 0; i < 3; i++) send(32'hB100_0000 + 32'(i));
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk0);
        chk("flush_refuse", 64'({in_ready, wr_en}), 64'd0);
        @(posedge clk0);
        #1 {in_valid, flush} = 2'b00;
        commit();
        // 70 beats from 0x20 with a 0x100 limit: full, capped, then partial after wrap.
        for (int i = 0; i < 70; i++) send(32'hC000_0000 + 32'(i));
        do_flush();
        repeat (2) @(negedge clk0);
        chk("words_142", 64'(words_written), 64'd142);
        chk("wrap_queue", 64'(cq.size()), 64'd0);
        @(posedge clk0);
        #1;
        fork
            for (int i = 0; i < 20; i++) send(32'hD000_0000 + 32'(i));
            begin
                repeat (5) @(posedge clk0);
                #1 wr_full = 1'b1;
                repeat (10) begin
                    @(negedge clk0);
                    chk("wr_full_hold", 64'(in_ready), 64'd0);
                    @(posedge clk0);
                    #1;
                end
                wr_full = 1'b0;
            end
        join
        do_flush();
        repeat (2) @(negedge clk0);
        chk("words_162", 64'(words_written), 64'd162);
        chk("data_drained", 64'(dq.size()), 64'd0);
        // cmd_full stall in CMD.
        do_reset();
        @(posedge clk0);
        #1 cmd_full = 1'b1;
        for (int i = 0; i < 32; i++) send(32'hE000_0000 + 32'(i));
`ifdef MEMC3_WR_TIMEOUT_EN
        repeat (1023) @(posedge clk0);
        @(negedge clk0);
        chk("to_before", 64'(error), 64'd0);
        @(negedge clk0);
        chk("to_error", 64'({error, err_code}), 64'b111);
`else
        repeat (1100) @(posedge clk0);
        @(negedge clk0);
        chk("stall_cmd_en", 64'(cmd_en), 64'd1);
        chk("stall_error", 64'(error), 64'd0);
        @(posedge clk0);
        #1 cmd_full = 1'b0;
        repeat (2) @(negedge clk0);
        chk("stall_release", 64'(words_written), 64'd32);
`endif
        // Underrun in IDLE.
        do_reset();
        @(posedge clk0);
        #1 wr_underrun = 1'b1;
        @(posedge clk0);
        #1 wr_underrun = 1'b0;
        @(negedge clk0);
        chk("underrun", 64'({error, err_code}), 64'b101);
        // Error during CMD abandons the burst.
        do_reset();
        @(posedge clk0);
        #1 cmd_full = 1'b1;
        for (int i = 0; i < 4; i++) send(32'hF000_0000 + 32'(i));
        do_flush();
        ww_hold = words_written;
        wr_error = 1'b1;
        @(posedge clk0);
        #1 {wr_error, cmd_full} = 2'b00;
        @(negedge clk0);
        chk("cmd_abandon_err", 64'({error, err_code, cmd_en}), 64'b1010);
        chk("cmd_abandon_ww", 64'(words_written), 64'(ww_hold));
        // Calibration lost mid-FILL: the beat in that cycle still lands, nothing after.
        do_reset();
        @(posedge clk0);
        #1;
        for (int i = 0; i < 3; i++) send(32'h1234_0000 + 32'(i));
        calib_done = 1'b0;
        send(32'h5555_AAAA);
        in_valid = 1'b1;
        @(negedge clk0);
        chk("cal_lost_code", 64'({error, err_code}), 64'b110);
        chk("cal_lost_wr_en", 64'({wr_en, in_ready}), 64'd0);
        chk("cal_lost_ww", 64'(words_written), 64'd0);
        in_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
